// File: rtl/cicero_cache_pkg.sv
// Shared types and defaults for the CICERO set-associative cache.
package cicero_cache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MISS_REQ,
        S_MISS_WAIT,
        S_FILL,
        S_FLUSH
    } cache_state_t;

    localparam int STAT_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/cache_set_lookup.sv
// Combinational tag compare across all ways of one set, plus the
// lowest-index invalid way used for victim selection.
module cache_set_lookup #(
    parameter int TAG_W = 11,
    parameter int WAYS  = 2,
    parameter int WB    = 1
) (
    input  logic [TAG_W-1:0]      tag,
    input  logic [WAYS*TAG_W-1:0] set_tags,
    input  logic [WAYS-1:0]       set_valid,
    output logic                  hit,
    output logic [WB-1:0]         hit_way,
    output logic [WB-1:0]         first_invalid_way,
    output logic                  any_invalid
);

    logic [WAYS-1:0] match;

    always_comb begin
        match             = '0;
        hit_way           = '0;
        first_invalid_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            match[w] = set_valid[w] && (set_tags[w*TAG_W +: TAG_W] == tag);
            if (match[w]) begin
                hit_way = hit_way | WB'(w);
            end
        end
        // Walk downwards so the lowest invalid index is the one left standing.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!set_valid[w]) begin
                first_invalid_way = WB'(w);
            end
        end
        hit         = |match;
        any_invalid = ~&set_valid;
    end

endmodule

// File: rtl/cache_set_assoc.sv
// Read-only blocking N-way set-associative cache with round-robin
// replacement, flush, and saturating hit/miss statistics.
module cache_set_assoc
    import cicero_cache_pkg::*;
#(
    parameter int DWIDTH     = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int SET_BITS   = 5,
    parameter int WAY_BITS   = 1,
    parameter int STAT_WIDTH = STAT_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [DWIDTH-1:0]     rsp_data,
    output logic                  mem_req_valid,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_req_ready,
    input  logic                  mem_rsp_valid,
    input  logic [DWIDTH-1:0]     mem_rsp_data,
    input  logic                  flush,
    output logic [STAT_WIDTH-1:0] hit_count,
    output logic [STAT_WIDTH-1:0] miss_count
);

    localparam int SETS  = 1 << SET_BITS;
    localparam int WAYS  = 1 << WAY_BITS;
    localparam int TAG_W = ADDR_WIDTH - SET_BITS;
    localparam int WB    = (WAY_BITS > 0) ? WAY_BITS : 1;

    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    cache_state_t state, state_nxt;

    logic [TAG_W-1:0]  tag_mem    [SETS][WAYS];
    logic [DWIDTH-1:0] data_mem   [SETS][WAYS];
    logic [WAYS-1:0]   valid_bits [SETS];
    logic [WB-1:0]     victim_ptr [SETS];
    logic [DWIDTH-1:0] fill_data;

    logic [ADDR_WIDTH-1:0]  lk_addr;
    logic [SET_BITS-1:0]    lk_set;
    logic [TAG_W-1:0]       lk_tag;
    logic [WAYS*TAG_W-1:0]  set_tags;
    logic                   hit, any_invalid;
    logic [WB-1:0]          hit_way, first_invalid_way, victim, victim_nxt;
    logic                   hit_acc, miss_acc, fill_rx;

    // Outside IDLE the only lookup of interest is for the outstanding miss.
    assign lk_addr = (state == S_IDLE) ? req_addr : mem_req_addr;
    assign lk_set  = lk_addr[SET_BITS-1:0];
    assign lk_tag  = lk_addr[ADDR_WIDTH-1:SET_BITS];

    always_comb begin
        set_tags = '0;
        for (int w = 0; w < WAYS; w++) begin
            set_tags[w*TAG_W +: TAG_W] = tag_mem[lk_set][w];
        end
    end

    cache_set_lookup #(
        .TAG_W (TAG_W),
        .WAYS  (WAYS),
        .WB    (WB)
    ) u_lookup (
        .tag               (lk_tag),
        .set_tags          (set_tags),
        .set_valid         (valid_bits[lk_set]),
        .hit               (hit),
        .hit_way           (hit_way),
        .first_invalid_way (first_invalid_way),
        .any_invalid       (any_invalid)
    );

    assign victim        = any_invalid ? first_invalid_way : victim_ptr[lk_set];
    assign victim_nxt    = (victim == WB'(WAYS - 1)) ? '0 : victim + 1'b1;
    assign req_ready     = (state == S_IDLE) && req_valid && !flush;
    assign hit_acc       = req_ready && hit;
    assign miss_acc      = req_ready && !hit;
    assign fill_rx       = (state == S_MISS_WAIT) && mem_rsp_valid;
    assign mem_req_valid = (state == S_MISS_REQ);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (flush)         state_nxt = S_FLUSH;
                else if (miss_acc) state_nxt = S_MISS_REQ;
            end
            S_MISS_REQ:  if (mem_req_ready) state_nxt = S_MISS_WAIT;
            S_MISS_WAIT: if (mem_rsp_valid) state_nxt = S_FILL;
            S_FILL:      state_nxt = S_IDLE;
            S_FLUSH:     state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            mem_req_addr <= '0;
            hit_count    <= '0;
            miss_count   <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_bits[s] <= '0;
                victim_ptr[s] <= '0;
            end
        end else begin
            state     <= state_nxt;
            rsp_valid <= hit_acc || fill_rx;
            if (hit_acc)      rsp_data <= data_mem[lk_set][hit_way];
            else if (fill_rx) rsp_data <= mem_rsp_data;
            if (miss_acc)     mem_req_addr <= req_addr;
            if (hit_acc)      hit_count  <= sat_inc(hit_count);
            if (miss_acc)     miss_count <= sat_inc(miss_count);
            if (state == S_FILL) begin
                valid_bits[lk_set][victim] <= 1'b1;
                victim_ptr[lk_set]         <= victim_nxt;
            end
            if (state == S_FLUSH) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_bits[s] <= '0;
                    victim_ptr[s] <= '0;
                end
            end
        end
    end

    // Line storage: no reset; a reset landing on the fill cycle must not write.
    always_ff @(posedge clk) begin
        if (fill_rx) fill_data <= mem_rsp_data;
        if (state == S_FILL && !rst) begin
            tag_mem[lk_set][victim]  <= lk_tag;
            data_mem[lk_set][victim] <= fill_data;
        end
    end

endmodule

// File: tb/tb_cache_set_assoc.sv
// Directed bench for cache_set_assoc at default parameters (2 ways, 32 sets).
module tb_cache_set_assoc;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [15:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        mem_req_valid;
    logic [15:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [15:0] mem_rsp_data;
    logic        flush;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int total = 0;
    int bad   = 0;
    int exp_hit  = 0;
    int exp_miss = 0;

    cache_set_assoc dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .flush         (flush),
        .hit_count     (hit_count),
        .miss_count    (miss_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request that should miss; memory answers after 4 cycles.
    task automatic miss_txn(input logic [15:0] addr, input logic [15:0] data,
                            output logic acc, output int nreq, output logic [15:0] raddr,
                            output logic early, output logic rv, output logic [15:0] rd);
        nreq = 0; early = 1'b0; raddr = '0;
        req_valid = 1'b1; req_addr = addr;
        #1 acc = req_ready;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (mem_req_valid && mem_req_ready) begin
                nreq++;
                raddr = mem_req_addr;
            end
            if (rsp_valid) early = 1'b1;
            tick();
        end
        mem_rsp_valid = 1'b1; mem_rsp_data = data;
        tick();
        mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        rv = rsp_valid; rd = rsp_data;
        tick();
    endtask

    // Issues one request expected to hit; samples the response one cycle later.
    task automatic hit_txn(input logic [15:0] addr, output logic acc, output logic mreq,
                           output logic rv, output logic [15:0] rd);
        req_valid = 1'b1; req_addr = addr;
        #1 acc = req_ready; mreq = mem_req_valid;
        tick();
        req_valid = 1'b0;
        rv = rsp_valid; rd = rsp_data;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_mem_req_valid got=%b exp=0", mem_req_valid); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
        total++; if (rsp_data !== 16'h0) begin bad++; $display("FAIL reset_rsp_data got=%h exp=0000", rsp_data); end
        total++; if (mem_req_addr !== 16'h0) begin bad++; $display("FAIL reset_mem_req_addr got=%h exp=0000", mem_req_addr); end
        total++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin bad++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", hit_count, miss_count); end
        tick();
    endtask

    task automatic test_cold_miss();
        logic acc, early, rv; int nreq; logic [15:0] raddr, rd;
        miss_txn(16'h0003, 16'hBEEF, acc, nreq, raddr, early, rv, rd);
        exp_miss++;
        total++; if (acc !== 1'b1) begin bad++; $display("FAIL cold_accept got=%b exp=1", acc); end
        total++; if (nreq !== 1) begin bad++; $display("FAIL cold_mem_req_count got=%0d exp=1", nreq); end
        total++; if (raddr !== 16'h0003) begin bad++; $display("FAIL cold_mem_req_addr got=%h exp=0003", raddr); end
        total++; if (early !== 1'b0) begin bad++; $display("FAIL cold_early_rsp got=%b exp=0", early); end
        total++; if (rv !== 1'b1 || rd !== 16'hBEEF) begin bad++; $display("FAIL cold_rsp got=%b/%h exp=1/beef", rv, rd); end
        total++; if (miss_count !== 32'(exp_miss) || hit_count !== 32'(exp_hit)) begin bad++; $display("FAIL cold_counters got=%0d/%0d exp=%0d/%0d", hit_count, miss_count, exp_hit, exp_miss); end
    endtask

    task automatic test_back_to_back();
        logic any_mreq = 1'b0;
        req_valid = 1'b1; req_addr = 16'h0003;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (mem_req_valid) any_mreq = 1'b1;
            total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_accept[%0d] got=%b exp=1", i, req_ready); end
            tick();
            exp_hit++;
            total++; if (rsp_valid !== 1'b1 || rsp_data !== 16'hBEEF) begin bad++; $display("FAIL b2b_rsp[%0d] got=%b/%h exp=1/beef", i, rsp_valid, rsp_data); end
        end
        req_valid = 1'b0;
        total++; if (hit_count !== 32'd3) begin bad++; $display("FAIL b2b_hit_count got=%0d exp=3", hit_count); end
        tick();
        if (mem_req_valid) any_mreq = 1'b1;
        total++; if (any_mreq !== 1'b0) begin bad++; $display("FAIL b2b_no_mem_req got=%b exp=0", any_mreq); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL b2b_rsp_drops got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_eviction();
        logic acc, early, rv, mreq; int nreq; logic [15:0] raddr, rd;
        miss_txn(16'h0023, 16'h1111, acc, nreq, raddr, early, rv, rd);
        exp_miss++;
        total++; if (nreq !== 1 || rd !== 16'h1111) begin bad++; $display("FAIL evict_fill23 got=%0d/%h exp=1/1111", nreq, rd); end
        miss_txn(16'h0043, 16'h2222, acc, nreq, raddr, early, rv, rd);
        exp_miss++;
        total++; if (nreq !== 1 || raddr !== 16'h0043 || rd !== 16'h2222) begin bad++; $display("FAIL evict_fill43 got=%0d/%h/%h exp=1/0043/2222", nreq, raddr, rd); end
        hit_txn(16'h0023, acc, mreq, rv, rd);
        exp_hit++;
        total++; if (acc !== 1'b1 || rv !== 1'b1 || rd !== 16'h1111) begin bad++; $display("FAIL evict_hit23 got=%b/%b/%h exp=1/1/1111", acc, rv, rd); end
        miss_txn(16'h0003, 16'hBEE2, acc, nreq, raddr, early, rv, rd);
        exp_miss++;
        total++; if (nreq !== 1 || early !== 1'b0 || rd !== 16'hBEE2) begin bad++; $display("FAIL evict_miss03 got=%0d/%b/%h exp=1/0/bee2", nreq, early, rd); end
        hit_txn(16'h0043, acc, mreq, rv, rd);
        exp_hit++;
        total++; if (rv !== 1'b1 || rd !== 16'h2222 || mreq !== 1'b0) begin bad++; $display("FAIL evict_keep43 got=%b/%h exp=1/2222", rv, rd); end
        total++; if (hit_count !== 32'(exp_hit) || miss_count !== 32'(exp_miss)) begin bad++; $display("FAIL evict_counters got=%0d/%0d exp=%0d/%0d", hit_count, miss_count, exp_hit, exp_miss); end
    endtask

    task automatic test_stall();
        logic stable = 1'b1;
        int   seen = 0;
        req_valid = 1'b1; req_addr = 16'h0105; mem_req_ready = 1'b0;
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL stall_accept got=%b exp=1", req_ready); end
        tick();
        exp_miss++;
        req_addr = 16'h0003;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== 16'h0105 || req_ready !== 1'b0) stable = 1'b0;
            tick();
        end
        total++; if (stable !== 1'b1) begin bad++; $display("FAIL stall_hold got=%b/%h/%b exp=1/0105/0", mem_req_valid, mem_req_addr, req_ready); end
        req_valid = 1'b0; mem_req_ready = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            if (mem_req_valid) seen++;
            tick();
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL stall_single_req got=%0d extra exp=0", seen); end
        mem_rsp_valid = 1'b1; mem_rsp_data = 16'h5A5A;
        tick();
        mem_rsp_valid = 1'b0;
        total++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h5A5A) begin bad++; $display("FAIL stall_rsp got=%b/%h exp=1/5a5a", rsp_valid, rsp_data); end
        tick();
        total++; if (miss_count !== 32'(exp_miss) || hit_count !== 32'(exp_hit)) begin bad++; $display("FAIL stall_counters got=%0d/%0d exp=%0d/%0d", hit_count, miss_count, exp_hit, exp_miss); end
    endtask

    task automatic test_flush_mid_miss();
        logic acc, early, rv; int nreq; logic [15:0] raddr, rd;
        req_valid = 1'b1; req_addr = 16'h0044;
        tick();
        exp_miss++;
        req_valid = 1'b0; flush = 1'b1;
        tick();
        tick();
        mem_rsp_valid = 1'b1; mem_rsp_data = 16'h7777;
        tick();
        mem_rsp_valid = 1'b0;
        total++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h7777) begin bad++; $display("FAIL flush_fill_rsp got=%b/%h exp=1/7777", rsp_valid, rsp_data); end
        tick();
        req_valid = 1'b1; req_addr = 16'h0043;
        #1;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL flush_blocks_req got=%b exp=0", req_ready); end
        tick();
        req_valid = 1'b0; flush = 1'b0;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL flush_no_rsp got=%b exp=0", rsp_valid); end
        tick();
        miss_txn(16'h0003, 16'hC0DE, acc, nreq, raddr, early, rv, rd);
        exp_miss++;
        total++; if (acc !== 1'b1 || nreq !== 1 || rd !== 16'hC0DE) begin bad++; $display("FAIL flush_miss03 got=%b/%0d/%h exp=1/1/c0de", acc, nreq, rd); end
        miss_txn(16'h0043, 16'hC0DF, acc, nreq, raddr, early, rv, rd);
        exp_miss++;
        total++; if (nreq !== 1 || rd !== 16'hC0DF) begin bad++; $display("FAIL flush_miss43 got=%0d/%h exp=1/c0df", nreq, rd); end
        total++; if (miss_count !== 32'(exp_miss) || hit_count !== 32'(exp_hit)) begin bad++; $display("FAIL flush_counters got=%0d/%0d exp=%0d/%0d", hit_count, miss_count, exp_hit, exp_miss); end
    endtask

    task automatic test_reset_mid_miss();
        logic acc, early, rv; int nreq; logic [15:0] raddr, rd;
        int rsp_seen = 0;
        req_valid = 1'b1; req_addr = 16'h0066;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_hit = 0; exp_miss = 0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 16'hDEAD;
        tick();
        mem_rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (rsp_valid || mem_req_valid) rsp_seen++;
            tick();
        end
        total++; if (rsp_seen !== 0) begin bad++; $display("FAIL rstmiss_stale_ignored got=%0d exp=0", rsp_seen); end
        total++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin bad++; $display("FAIL rstmiss_counters got=%0d/%0d exp=0/0", hit_count, miss_count); end
        miss_txn(16'h0066, 16'h6666, acc, nreq, raddr, early, rv, rd);
        exp_miss++;
        total++; if (acc !== 1'b1 || nreq !== 1 || raddr !== 16'h0066 || rv !== 1'b1 || rd !== 16'h6666) begin bad++; $display("FAIL rstmiss_next_miss got=%b/%0d/%h/%b/%h exp=1/1/0066/1/6666", acc, nreq, raddr, rv, rd); end
        miss_txn(16'h0003, 16'h0303, acc, nreq, raddr, early, rv, rd);
        exp_miss++;
        total++; if (nreq !== 1 || rd !== 16'h0303) begin bad++; $display("FAIL rstmiss_lines_cleared got=%0d/%h exp=1/0303", nreq, rd); end
        total++; if (miss_count !== 32'(exp_miss)) begin bad++; $display("FAIL rstmiss_miss_count got=%0d exp=%0d", miss_count, exp_miss); end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        test_reset();
        test_cold_miss();
        test_back_to_back();
        test_eviction();
        test_stall();
        test_flush_mid_miss();
        test_reset_mid_miss();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
